alu_exec_unit: RTL



---
 rtl/alu_exec_if.sv | 32 +++
 rtl/alu_exec_unit.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/alu_exec_if.sv
// Issue-side and CDB-side handshake bundle for the integer execution unit.
// The master drives operations and CDB back-pressure; the slave is the execution unit.
interface alu_exec_if #(
    parameter int XLEN  = 32,
    parameter int TAG_W = 6
);
    logic             flush;
    logic             issue_valid;
    logic             issue_ready;
    logic [3:0]       alu_op;
    logic [2:0]       funct3;
    logic             funct7_b5;
    logic [XLEN-1:0]  operand_a;
    logic [XLEN-1:0]  operand_b;
    logic [TAG_W-1:0] tag_in;
    logic             cdb_valid;
    logic             cdb_ready;
    logic [XLEN-1:0]  cdb_data;
    logic [TAG_W-1:0] cdb_tag;

    modport master (
        output flush, issue_valid, alu_op, funct3, funct7_b5,
               operand_a, operand_b, tag_in, cdb_ready,
        input  issue_ready, cdb_valid, cdb_data, cdb_tag
    );

    modport slave (
        input  flush, issue_valid, alu_op, funct3, funct7_b5,
               operand_a, operand_b, tag_in, cdb_ready,
        output issue_ready, cdb_valid, cdb_data, cdb_tag
    );
endinterface

// File: rtl/alu_exec_unit.sv
// Integer execution unit: single-cycle ALU ops plus a MUL_LAT-cycle multiply, tagged result onto the CDB.
// Result register holds until cdb_ready; issue stalls while multiplying or while an unconsumed result is held.
module alu_exec_unit #(
    parameter int XLEN    = 32,
    parameter int TAG_W   = 6,
    parameter int MUL_LAT = 3
) (
    input  logic      clk,
    input  logic      rst,
    alu_exec_if.slave bus
);
    localparam int SH_W = $clog2(XLEN);

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MUL_BUSY = 2'd1;
    localparam logic [1:0] S_HOLD     = 2'd2;

    localparam logic [3:0] OP_ADD  = 4'd0;
    localparam logic [3:0] OP_SUB  = 4'd1;
    localparam logic [3:0] OP_MUL  = 4'd2;
    localparam logic [3:0] OP_SLL  = 4'd3;
    localparam logic [3:0] OP_SLT  = 4'd4;
    localparam logic [3:0] OP_XOR  = 4'd5;
    localparam logic [3:0] OP_SR   = 4'd6;
    localparam logic [3:0] OP_OR   = 4'd7;
    localparam logic [3:0] OP_AND  = 4'd8;
    localparam logic [3:0] OP_SLLI = 4'd9;
    localparam logic [3:0] OP_SRI  = 4'd10;

    localparam logic [3:0] MUL_CNT_INIT = 4'(MUL_LAT - 1);

    function automatic logic [XLEN-1:0] alu_result(
        input logic [3:0]      op,
        input logic [2:0]      f3,
        input logic            f7_b5,
        input logic [XLEN-1:0] a,
        input logic [XLEN-1:0] b
    );
        logic [SH_W-1:0] sh;
        logic [XLEN-1:0] sra_a;
        logic [XLEN-1:0] srl_a;
        logic            lt;
        logic [XLEN-1:0] r;
        sh    = b[SH_W-1:0];
        sra_a = $unsigned($signed(a) >>> sh);
        srl_a = a >> sh;
        lt    = (f3 == 3'b011) ? (a < b) : ($signed(a) < $signed(b));
        r     = '0;
        case (op)
            OP_ADD:          r = a + b;
            OP_SUB:          r = a - b;
            OP_MUL:          r = a * b;
            OP_SLL, OP_SLLI: r = a << sh;
            OP_SLT:          r = {{(XLEN-1){1'b0}}, lt};
            OP_XOR:          r = a ^ b;
            OP_SR:           r = f7_b5 ? sra_a : srl_a;
            OP_OR:           r = a | b;
            OP_AND:          r = a & b;
            // immediate form: imm[10] carries the arithmetic select
            OP_SRI:          r = b[10] ? sra_a : srl_a;
            default:         r = '0;
        endcase
        return r;
    endfunction

    logic [1:0]       state;
    logic [3:0]       mul_cnt;
    logic [XLEN-1:0]  mul_a;
    logic [XLEN-1:0]  mul_b;
    logic [TAG_W-1:0] mul_tag;
    logic             res_vld;
    logic [XLEN-1:0]  res_data;
    logic [TAG_W-1:0] res_tag;
    logic             ready;
    logic             accept;
    logic             is_mul;

    assign ready  = (state != S_MUL_BUSY) && (!res_vld || bus.cdb_ready) && !bus.flush;
    assign accept = bus.issue_valid && ready;
    assign is_mul = (bus.alu_op == OP_MUL);

    assign bus.issue_ready = ready;
    assign bus.cdb_valid   = res_vld;
    assign bus.cdb_data    = res_data;
    assign bus.cdb_tag     = res_tag;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_IDLE;
            mul_cnt  <= '0;
            mul_a    <= '0;
            mul_b    <= '0;
            mul_tag  <= '0;
            res_vld  <= 1'b0;
            res_data <= '0;
            res_tag  <= '0;
        end else if (bus.flush) begin
            state    <= S_IDLE;
            mul_cnt  <= '0;
            res_vld  <= 1'b0;
            res_data <= '0;
            res_tag  <= '0;
        end else begin
            case (state)
                S_MUL_BUSY: begin
                    // count of 1 means this edge is the last of the multiply window
                    if (mul_cnt == 4'd1) begin
                        state    <= S_HOLD;
                        mul_cnt  <= '0;
                        res_vld  <= 1'b1;
                        res_data <= mul_a * mul_b;
                        res_tag  <= mul_tag;
                    end else begin
                        mul_cnt <= mul_cnt - 4'd1;
                    end
                end
                default: begin
                    if (accept) begin
                        if (is_mul && (MUL_LAT > 1)) begin
                            state    <= S_MUL_BUSY;
                            mul_cnt  <= MUL_CNT_INIT;
                            mul_a    <= bus.operand_a;
                            mul_b    <= bus.operand_b;
                            mul_tag  <= bus.tag_in;
                            res_vld  <= 1'b0;
                            res_data <= '0;
                            res_tag  <= '0;
                        end else begin
                            state    <= S_HOLD;
                            res_vld  <= 1'b1;
                            res_data <= alu_result(bus.alu_op, bus.funct3, bus.funct7_b5,
                                                   bus.operand_a, bus.operand_b);
                            res_tag  <= bus.tag_in;
                        end
                    end else if (res_vld && bus.cdb_ready) begin
                        state    <= S_IDLE;
                        res_vld  <= 1'b0;
                        res_data <= '0;
                        res_tag  <= '0;
                    end
                end
            endcase
        end
    end
endmodule
